// File: rtl/scrambler_key_gen_pkg.sv
// Shared types, constants and the seed fold for the line-key scrambler.
package scrambler_key_gen_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_LOAD,
        ST_IDLE,
        ST_GEN,
        ST_DONE
    } state_e;

    localparam int          SEED_W    = 256;
    localparam int          KEY_W     = 8;
    localparam int          LFSR_W    = 32;
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    // An all-zero fold would lock the LFSR at zero, so it is replaced by 1.
    function automatic logic [LFSR_W-1:0] fold_seed(input logic [SEED_W-1:0] seed);
        logic [LFSR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < SEED_W / LFSR_W; i++) begin
            acc = acc ^ seed[i*LFSR_W +: LFSR_W];
        end
        return (acc == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : acc;
    endfunction

endpackage

// File: rtl/scrambler_key_gen_if.sv
// Configuration, line/frame control and key result signals of the scrambler key generator.
interface scrambler_key_gen_if;
    import scrambler_key_gen_pkg::*;

    logic              reset_n_scrambler;
    logic              MODE;
    logic [SEED_W-1:0] seed;
    logic              frame_start;
    logic              line_start;
    logic [KEY_W-1:0]  key;
    logic              key_valid;
    logic              busy;
    logic              overrun;

    modport master (
        output reset_n_scrambler, MODE, seed, frame_start, line_start,
        input  key, key_valid, busy, overrun
    );

    modport slave (
        input  reset_n_scrambler, MODE, seed, frame_start, line_start,
        output key, key_valid, busy, overrun
    );

endinterface

// File: rtl/scrambler_lfsr32.sv
// 32-bit Galois LFSR that shifts right, with a parallel load and a single-step control.
module scrambler_lfsr32 import scrambler_key_gen_pkg::*; (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_i,
    input  logic [LFSR_W-1:0] load_value_i,
    input  logic              step_i,
    output logic              bit_o
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = load_value_i;
        end else if (step_i) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_POLY : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lfsr_q <= {{(LFSR_W-1){1'b0}}, 1'b1};
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign bit_o = lfsr_q[0];

endmodule

// File: rtl/scrambler_key_gen.sv
// Per-line cut-point key generator: 8 LFSR bits per line, folded into 0..KEY_MAX.
module scrambler_key_gen #(
    parameter int unsigned KEY_MAX = 179
) (
    input  logic               clk,
    input  logic               reset_n,
    scrambler_key_gen_if.slave bus
);
    import scrambler_key_gen_pkg::*;

    localparam logic [KEY_W-1:0] KEY_LIMIT  = KEY_W'(KEY_MAX);
    localparam logic [KEY_W-1:0] KEY_OFFSET = KEY_W'(KEY_MAX + 1);

    state_e            state_q;
    logic [KEY_W-1:0]  raw_q;
    logic [KEY_W-1:0]  key_q;
    logic [2:0]        bit_cnt_q;
    logic              key_valid_q;
    logic              busy_q;
    logic              overrun_q;

    logic              lfsr_load;
    logic              lfsr_step;
    logic              lfsr_bit;
    logic [LFSR_W-1:0] seed_fold;
    logic              line_dropped;

    function automatic logic [KEY_W-1:0] map_key(input logic [KEY_W-1:0] raw,
                                                 input logic scramble);
        if (!scramble) return '0;
        if (raw > KEY_LIMIT) return raw - KEY_OFFSET;
        return raw;
    endfunction

    assign seed_fold = fold_seed(bus.seed);
    assign lfsr_load = (state_q == ST_LOAD);
    // The LFSR only advances on GEN cycles that are not being aborted.
    assign lfsr_step = (state_q == ST_GEN) && bus.reset_n_scrambler && !bus.frame_start;

    assign line_dropped = bus.line_start &&
                          ((state_q == ST_LOAD) || (state_q == ST_GEN) || (state_q == ST_DONE) ||
                           ((state_q == ST_IDLE) && bus.frame_start));

    scrambler_lfsr32 u_lfsr (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_i       (lfsr_load),
        .load_value_i (seed_fold),
        .step_i       (lfsr_step),
        .bit_o        (lfsr_bit)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            raw_q       <= '0;
            bit_cnt_q   <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            overrun_q   <= line_dropped;
            if (!bus.reset_n_scrambler) begin
                state_q <= ST_INIT;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_INIT: begin
                        state_q <= ST_LOAD;
                        busy_q  <= 1'b1;
                    end
                    ST_LOAD: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    ST_IDLE: begin
                        if (bus.frame_start) begin
                            state_q <= ST_LOAD;
                            busy_q  <= 1'b1;
                        end else if (bus.line_start) begin
                            state_q   <= ST_GEN;
                            bit_cnt_q <= '0;
                            busy_q    <= 1'b1;
                        end
                    end
                    ST_GEN: begin
                        if (bus.frame_start) begin
                            state_q <= ST_LOAD;
                        end else begin
                            raw_q     <= {raw_q[KEY_W-2:0], lfsr_bit};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                state_q <= ST_DONE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (bus.frame_start) begin
                            state_q <= ST_LOAD;
                            busy_q  <= 1'b1;
                        end else begin
                            key_q       <= map_key(raw_q, bus.MODE);
                            key_valid_q <= 1'b1;
                            state_q     <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_q <= ST_INIT;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.key       = key_q;
    assign bus.key_valid = key_valid_q;
    assign bus.busy      = busy_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: doc/scrambler_key_gen.md
SCRAMBLER_KEY_GEN -- requirements
Module: scrambler_key_gen

Interface
REQ-001 Parameter KEY_MAX, default 179, largest cut-point value emitted; legal range 127..254.
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 reset_n_scrambler  input  1  from the ROM configuration reader; low = config not loaded or held off, high = seed/MODE valid and stable.
REQ-005 MODE  input  1  0 = bypass (key forced 0), 1 = scramble.
REQ-006 seed  input  256  scrambler seed, big-endian byte order, valid while reset_n_scrambler high.
REQ-007 frame_start  input  1  one-cycle pulse; restart key sequence.
REQ-008 line_start  input  1  one-cycle pulse; request one line key.
REQ-009 key  output  8  cut point for current line, 0..KEY_MAX.
REQ-010 key_valid  output  1  one-cycle strobe qualifying key.
REQ-011 busy  output  1  high in LOAD and GEN states.
REQ-012 overrun  output  1  one-cycle pulse when a line_start is dropped.

Function
REQ-013 FSM states: INIT, LOAD, IDLE, GEN, DONE.
REQ-014 INIT: wait for reset_n_scrambler high, then go to LOAD.
REQ-015 LOAD, one cycle: lfsr = XOR of the eight 32-bit seed words, seed[31:0] through seed[255:224]; if that XOR is zero, lfsr = 32'h0000_0001. Then go to IDLE.
REQ-016 IDLE: on frame_start go to LOAD; otherwise on line_start go to GEN with bit counter 0.
REQ-017 GEN lasts exactly 8 cycles. Each cycle: bit b = lfsr[0]; lfsr = (lfsr >> 1) XOR (b ? 32'h8020_0003 : 0); raw = {raw[6:0], b}. The first bit ends up as raw[7].
REQ-018 DONE, one cycle: key_valid = 1, then return to IDLE.
REQ-019 Key value:
- MODE = 1 and raw > KEY_MAX: key = raw - (KEY_MAX+1).
- MODE = 1 otherwise: key = raw.
- MODE = 0: key = 0; the LFSR still advances so MODE changes keep sequence alignment.
REQ-020 key holds its value until the next DONE.
REQ-021 Latency: line_start sampled in IDLE at edge t gives key_valid high during the cycle after edge t+9.
REQ-022 line_start in LOAD, GEN or DONE is dropped and pulses overrun the following cycle; there is no queueing.
REQ-023 frame_start in GEN or DONE aborts the line: no key_valid, go to LOAD.
REQ-024 frame_start and line_start in the same IDLE cycle: frame_start wins, line_start counts as dropped (overrun).
REQ-025 frame_start in LOAD or INIT is ignored.
REQ-026 reset_n_scrambler low in any state: go to INIT next cycle, key_valid 0, busy 0; key retains its value.

Reset
REQ-027 reset_n low at a clock edge sets:
- state = INIT, lfsr = 32'h0000_0001, raw = 0, bit counter = 0
- key = 0, key_valid = 0, busy = 0, overrun = 0
REQ-028 Reset overrides all other inputs in the same cycle.

Structure
REQ-029 Shared package holds the FSM state encoding, the LFSR polynomial constant 32'h8020_0003, the seed width 256 and the key width 8.
REQ-030 One sub-module, scrambler_lfsr32, holds the 32-bit Galois LFSR with load and step controls; the fold and key range-mapping stay in the parent.

Verification
REQ-031 Seed = 0, MODE = 1, release reset_n_scrambler, one line_start: lfsr loads 1, raw = 8'hDB, key = 8'd39, key_valid exactly 10 cycles after line_start.
REQ-032 Same stimulus with MODE = 0: key = 0, key_valid at same timing. Then set MODE = 1 and issue a second line: that key equals the second key of the REQ-031 sequence.
REQ-033 Issue a line_start during GEN: overrun pulses once, exactly one key_valid is produced, and the key equals the single-line value.
REQ-034 After 3 lines, pulse frame_start, then issue line_start: key = 8'd39 again (seed = 0). Also drive frame_start together with line_start in IDLE: LOAD occurs, overrun pulses, no key_valid.
REQ-035 Drop reset_n_scrambler low in the 4th GEN cycle: no key_valid, busy 0 the next cycle. Re-raise it: INIT -> LOAD -> IDLE, and the next key = 8'd39.
REQ-036 Use random seeds, compare against a reference model over 1000 lines, and check every key <= KEY_MAX with KEY_MAX set to 127 and to 254.
